// File: rtl/alu_loader_pkg.sv
// rtl/alu_loader_pkg.sv - shared encodings for the ALU operand loader
//
// Purpose: loader FSM state encodings, ALU opcode constants and word geometry.
// Ports:   none (package).
package alu_loader_pkg;

    typedef enum logic [1:0] {
        LOAD_A  = 2'b00,
        LOAD_B  = 2'b01,
        WAIT_GO = 2'b10,
        ISSUE   = 2'b11
    } state_e;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_XOR = 3'b010;
    localparam logic [2:0] OP_ADD = 3'b011;
    localparam logic [2:0] OP_SUB = 3'b100;
    localparam logic [2:0] OP_SLT = 3'b101;
    localparam logic [2:0] OP_SRL = 3'b110;
    localparam logic [2:0] OP_SLL = 3'b111;

    localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/alu_operand_loader_btn_pulse.sv
// rtl/alu_operand_loader_btn_pulse.sv - button synchronizer, optional debounce, rising-edge pulse
//
// Purpose: turns a raw asynchronous button into a single-cycle pulse per press.
//          Optional debounce enabled by macro ALU_LOADER_DEBOUNCE_EN.
// Ports:
//   clk      in   system clock
//   rst_n    in   asynchronous active-low reset
//   btn_i    in   raw button pin
//   pulse_o  out  one-cycle pulse, high in the cycle before the 3rd clk edge
//                 after the pin rises (plus DBNC_CYCLES when debounced)
module btn_pulse #(
    parameter logic [15:0] DBNC_CYCLES = 16'd50000,
    parameter int          DBNC_W      = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic pulse_o
);

    logic [1:0] sync_q;
    logic       prev_q;
    logic       level;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], btn_i};
        end
    end

`ifdef ALU_LOADER_DEBOUNCE_EN
    logic              db_q;
    logic              db_d;
    logic [DBNC_W-1:0] cnt_q;
    logic [DBNC_W-1:0] cnt_d;

    // The counter only runs while the synchronized pin disagrees with the
    // debounced level; any return to the old level restarts the stable-time.
    always_comb begin
        db_d  = db_q;
        cnt_d = '0;
        if (sync_q[1] != db_q) begin
            if (cnt_q == DBNC_W'(DBNC_CYCLES - 16'd1)) begin
                db_d = sync_q[1];
            end else begin
                cnt_d = cnt_q + DBNC_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_q  <= 1'b0;
            cnt_q <= '0;
        end else begin
            db_q  <= db_d;
            cnt_q <= cnt_d;
        end
    end

    assign level = db_q;
`else
    logic unused_dbnc;
    assign unused_dbnc = ^{DBNC_CYCLES, DBNC_W[0]};
    assign level       = sync_q[1];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= level;
        end
    end

    // Consumed only by registered logic in the top, so outputs stay registered.
    assign pulse_o = level & ~prev_q;

endmodule

// File: rtl/alu_operand_loader.sv
// rtl/alu_operand_loader.sv - byte-wise operand/opcode loader with valid/ready issue to the ALU
//
// Purpose: assembles 32-bit operands A and B from switch bytes (LSB first),
//          captures an opcode and hands {A, B, op} to the ALU via valid/ready.
//          Optional button debounce enabled by macro ALU_LOADER_DEBOUNCE_EN.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   byte_sw[7:0]    operand byte from switches
//   op_sw[2:0]      opcode from switches
//   load_btn        store one byte per press
//   go_btn          issue the operation
//   abort_btn       restart loading
//   op_ready        consumer accepts transfer
//   a_out, b_out    operand registers
//   alu_op_out      captured opcode
//   op_valid        transfer request
//   state_out       current state (LEDs)
//   byte_idx        next byte slot (LEDs)
module alu_operand_loader
    import alu_loader_pkg::*;
#(
    parameter logic [15:0] DBNC_CYCLES = 16'd50000,
    parameter int          DBNC_W      = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  byte_sw,
    input  logic [2:0]  op_sw,
    input  logic        load_btn,
    input  logic        go_btn,
    input  logic        abort_btn,
    input  logic        op_ready,
    output logic [31:0] a_out,
    output logic [31:0] b_out,
    output logic [2:0]  alu_op_out,
    output logic        op_valid,
    output logic [1:0]  state_out,
    output logic [1:0]  byte_idx
);

    localparam logic [1:0] LAST_SLOT = 2'(BYTES_PER_WORD - 1);

    logic ld_p, go_p, ab_p;

    state_e      state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [2:0]  op_q, op_d;
    logic        valid_q, valid_d;

    btn_pulse #(.DBNC_CYCLES(DBNC_CYCLES), .DBNC_W(DBNC_W)) u_ld_pulse (
        .clk(clk), .rst_n(rst_n), .btn_i(load_btn), .pulse_o(ld_p)
    );
    btn_pulse #(.DBNC_CYCLES(DBNC_CYCLES), .DBNC_W(DBNC_W)) u_go_pulse (
        .clk(clk), .rst_n(rst_n), .btn_i(go_btn), .pulse_o(go_p)
    );
    btn_pulse #(.DBNC_CYCLES(DBNC_CYCLES), .DBNC_W(DBNC_W)) u_ab_pulse (
        .clk(clk), .rst_n(rst_n), .btn_i(abort_btn), .pulse_o(ab_p)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        valid_d = valid_q;

        // Abort wins over everything, including a handshake completing this cycle.
        if (ab_p) begin
            state_d = LOAD_A;
            idx_d   = 2'd0;
            valid_d = 1'b0;
        end else begin
            case (state_q)
                LOAD_A: begin
                    if (ld_p) begin
                        a_d[8*idx_q +: 8] = byte_sw;
                        idx_d             = idx_q + 2'd1;
                        if (idx_q == LAST_SLOT) begin
                            state_d = LOAD_B;
                        end
                    end
                end
                LOAD_B: begin
                    if (ld_p) begin
                        b_d[8*idx_q +: 8] = byte_sw;
                        idx_d             = idx_q + 2'd1;
                        if (idx_q == LAST_SLOT) begin
                            state_d = WAIT_GO;
                        end
                    end
                end
                WAIT_GO: begin
                    if (go_p) begin
                        op_d    = op_sw;
                        valid_d = 1'b1;
                        state_d = ISSUE;
                    end
                end
                ISSUE: begin
                    if (valid_q && op_ready) begin
                        valid_d = 1'b0;
                        idx_d   = 2'd0;
                        state_d = LOAD_A;
                    end
                end
                default: begin
                    state_d = LOAD_A;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LOAD_A;
            idx_q   <= 2'd0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            valid_q <= valid_d;
        end
    end

    assign a_out      = a_q;
    assign b_out      = b_q;
    assign alu_op_out = op_q;
    assign op_valid   = valid_q;
    assign state_out  = state_q;
    assign byte_idx   = idx_q;

endmodule

// File: tb/tb_alu_operand_loader.sv
// tb/tb_alu_operand_loader.sv - directed self-checking bench for alu_operand_loader
module tb_alu_operand_loader;

`ifdef ALU_LOADER_DEBOUNCE_EN
    localparam int LAT = 3 + 4;
`else
    localparam int LAT = 3;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  byte_sw = 8'h00;
    logic [2:0]  op_sw = 3'b000;
    logic        load_btn = 1'b0;
    logic        go_btn = 1'b0;
    logic        abort_btn = 1'b0;
    logic        op_ready = 1'b0;
    logic [31:0] a_out, b_out;
    logic [2:0]  alu_op_out;
    logic        op_valid;
    logic [1:0]  state_out, byte_idx;

    int errors = 0;
    int checks = 0;

    alu_operand_loader #(.DBNC_CYCLES(16'd4), .DBNC_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .byte_sw(byte_sw), .op_sw(op_sw),
        .load_btn(load_btn), .go_btn(go_btn), .abort_btn(abort_btn),
        .op_ready(op_ready), .a_out(a_out), .b_out(b_out),
        .alu_op_out(alu_op_out), .op_valid(op_valid),
        .state_out(state_out), .byte_idx(byte_idx)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic press(input logic [7:0] b, input logic ld, input logic go, input logic ab);
        @(negedge clk);
        byte_sw = b; load_btn = ld; go_btn = go; abort_btn = ab;
        repeat (LAT + 2) @(negedge clk);
        load_btn = 1'b0; go_btn = 1'b0; abort_btn = 1'b0;
        repeat (LAT + 2) @(negedge clk);
    endtask

    task automatic load_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) press(w[8*i +: 8], 1'b1, 1'b0, 1'b0);
    endtask

    // Issues go, counts sampled cycles with op_valid high and raises op_ready
    // on the ready_at-th such cycle (0 = ready already high).
    task automatic issue(input logic [2:0] op, input int ready_at,
                         input logic [31:0] ea, input logic [31:0] eb, output int cnt);
        logic stable;
        int   t;
        cnt = 0; stable = 1'b1; t = 0;
        op_sw = op;
        op_ready = (ready_at == 0);
        @(negedge clk);
        go_btn = 1'b1;
        while (!op_valid && t < 30) begin
            @(negedge clk);
            t++;
        end
        check("valid_rises", {31'd0, op_valid}, 32'd1);
        for (int k = 0; k < 30 && op_valid; k++) begin
            cnt++;
            if (a_out !== ea || b_out !== eb || alu_op_out !== op) stable = 1'b0;
            if (cnt == ready_at) op_ready = 1'b1;
            @(negedge clk);
        end
        check("issue_stable", {31'd0, stable}, 32'd1);
        go_btn = 1'b0; op_ready = 1'b0;
        repeat (LAT + 2) @(negedge clk);
    endtask

    int cnt;

    initial begin
        repeat (3) @(negedge clk);
        check("rst_a", a_out, 32'd0);
        check("rst_b", b_out, 32'd0);
        check("rst_valid", {31'd0, op_valid}, 32'd0);
        check("rst_state", {30'd0, state_out}, 32'd0);
        check("rst_idx", {30'd0, byte_idx}, 32'd0);
        rst_n = 1'b1;

        // Plan 1: assemble A and B LSB first
        load_word(32'h1234_5678);
        check("t1_state_after_a", {30'd0, state_out}, 32'd1);
        load_word(32'h3333_2222);
        check("t1_a", a_out, 32'h1234_5678);
        check("t1_b", b_out, 32'h3333_2222);
        check("t1_state", {30'd0, state_out}, 32'd2);
        check("t1_idx", {30'd0, byte_idx}, 32'd0);

        // Plan 2: ready low for 5 valid cycles, then high
        issue(3'b100, 6, 32'h1234_5678, 32'h3333_2222, cnt);
        check("t2_valid_cycles", cnt, 32'd6);
        check("t2_op", {29'd0, alu_op_out}, 32'h4);
        check("t2_state", {30'd0, state_out}, 32'd0);
        check("t2_valid_low", {31'd0, op_valid}, 32'd0);

        // Plan 3: held load button stores one byte, with fixed latency
        @(negedge clk);
        byte_sw = 8'hFF; load_btn = 1'b1;
        repeat (LAT - 1) @(negedge clk);
        check("t3_not_early", {30'd0, byte_idx}, 32'd0);
        @(negedge clk);
        check("t3_on_time", {30'd0, byte_idx}, 32'd1);
        repeat (100 - LAT) @(negedge clk);
        load_btn = 1'b0;
        repeat (LAT + 2) @(negedge clk);
        check("t3_idx_hold", {30'd0, byte_idx}, 32'd1);
        check("t3_a", a_out, 32'h1234_56FF);

        // Plan 4: second FF byte, then abort keeps stale/partial operand
        press(8'hFF, 1'b1, 1'b0, 1'b0);
        check("t4_idx2", {30'd0, byte_idx}, 32'd2);
        press(8'h00, 1'b0, 1'b0, 1'b1);
        check("t4_state", {30'd0, state_out}, 32'd0);
        check("t4_idx", {30'd0, byte_idx}, 32'd0);
        check("t4_a", a_out, 32'h1234_FFFF);

        // ready already high: single-cycle valid
        load_word(32'hDEAD_BEEF);
        load_word(32'h0BAD_F00D);
        issue(3'b111, 0, 32'hDEAD_BEEF, 32'h0BAD_F00D, cnt);
        check("rdy_hi_cycles", cnt, 32'd1);
        check("rdy_hi_op", {29'd0, alu_op_out}, 32'h7);

        // Plan 6: load+go together in LOAD_B at slot 3
        load_word(32'hCAFE_0001);
        press(8'h01, 1'b1, 1'b0, 1'b0);
        press(8'h02, 1'b1, 1'b0, 1'b0);
        press(8'h03, 1'b1, 1'b0, 1'b0);
        check("t6_idx3", {30'd0, byte_idx}, 32'd3);
        press(8'hAB, 1'b1, 1'b1, 1'b0);
        check("t6_b", b_out, 32'hAB03_0201);
        check("t6_state", {30'd0, state_out}, 32'd2);
        check("t6_no_valid", {31'd0, op_valid}, 32'd0);

        // Plan 5: async reset in the middle of ISSUE
        @(negedge clk);
        op_ready = 1'b0; op_sw = 3'b011; go_btn = 1'b1;
        repeat (LAT + 1) @(negedge clk);
        go_btn = 1'b0;
        check("t5_in_issue", {30'd0, state_out}, 32'd3);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("t5_valid", {31'd0, op_valid}, 32'd0);
        check("t5_a", a_out, 32'd0);
        check("t5_b", b_out, 32'd0);
        check("t5_state", {30'd0, state_out}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

`ifdef ALU_LOADER_DEBOUNCE_EN
        // 2-cycle glitch shorter than the stable time
        byte_sw = 8'h5A; load_btn = 1'b1;
        repeat (2) @(negedge clk);
        load_btn = 1'b0;
        repeat (20) @(negedge clk);
        check("glitch_idx", {30'd0, byte_idx}, 32'd0);
        check("glitch_a", a_out, 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_operand_loader.md
Name: alu_operand_loader

Overview:
Sequential front end for the 32-bit ALU. It assembles operands A and B byte by byte from 8 slide switches and a load button, captures a 3-bit opcode, and hands {A, B, op} to the ALU with a valid/ready handshake. It mirrors the byte-wise LED result readout, so results leave 8 bits at a time and operands enter 8 bits at a time.

Parameters:
DBNC_CYCLES, 16'd50000, debounce stable-time in clk cycles (used only with DEBOUNCE_EN)
DBNC_W, 16, width of debounce counter

Ports:
clk  input  1  system clock
rst_n  input  1  reset; asynchronous, active-low
byte_sw  input  8  operand byte from switches
op_sw  input  3  ALU opcode from switches (same encoding as ALU: 000 AND … 111 SLL)
load_btn  input  1  raw button; each press stores one byte
go_btn  input  1  raw button; issues operation
abort_btn  input  1  raw button; restart loading
op_ready  input  1  ALU/consumer accepts transfer
a_out  output  32  operand A register
b_out  output  32  operand B register
alu_op_out  output  3  captured opcode
op_valid  output  1  transfer request to ALU
state_out  output  2  current state, for LEDs
byte_idx  output  2  next byte slot, for LEDs

Behaviour:
- Reset (async assert, sync deassert by design): a_out=0, b_out=0, alu_op_out=0, op_valid=0, byte_idx=0, state=LOAD_A (state_out=2'b00), all sync/edge flops=0.
- Each button passes through a 2-flop synchronizer plus a rising-edge detector. It yields a one-cycle pulse (ld_p, go_p, ab_p) on the 3rd rising clk edge after the pin goes high. A held button yields exactly one pulse.
- States: LOAD_A=00, LOAD_B=01, WAIT_GO=10, ISSUE=11.
- LOAD_A: on ld_p, a_out[8*byte_idx +: 8] <= byte_sw and byte_idx++. Bytes load LSB first, so slot 0 goes to bits 7:0. On the pulse at byte_idx==3: byte_idx wraps to 0 and state -> LOAD_B.
- LOAD_B: same as LOAD_A but writes b_out. At byte_idx==3 -> WAIT_GO.
- WAIT_GO: ld_p ignored. On go_p: alu_op_out <= op_sw, op_valid <= 1, state -> ISSUE.
- ISSUE: op_valid held at 1; a_out, b_out and alu_op_out held stable. The transfer completes on a cycle with op_valid && op_ready; then op_valid <= 0, state -> LOAD_A, byte_idx=0. ld_p and go_p are ignored here.
- op_ready already high when ISSUE is entered: op_valid is high for exactly 1 cycle.
- abort (ab_p), any state: state -> LOAD_A, byte_idx=0, op_valid=0. Operand registers are unchanged. Abort has priority over ld_p and go_p in the same cycle, and also over a completing handshake.
- Partially loaded operands keep their stale upper bytes until overwritten.
- Reset asserted mid-operation: everything returns immediately to reset values, including a pending op_valid.
- All outputs are registered; no combinational path from inputs to outputs.

Optional Feature:
- Macro: ALU_LOADER_DEBOUNCE_EN.
- Defined: each synchronized button must stay at a new level for DBNC_CYCLES consecutive cycles before the debounced level changes. Edge detection runs on the debounced level, so pulse latency becomes 3+DBNC_CYCLES cycles. Glitches shorter than DBNC_CYCLES produce no pulse.
- Undefined: no debounce counter; behaviour exactly as above (latency 3).

Decomposition:
- Package alu_loader_pkg holds:
  - state encodings LOAD_A/LOAD_B/WAIT_GO/ISSUE
  - opcode constants OP_AND … OP_SLL (3'b000 … 3'b111)
  - BYTES_PER_WORD=4
- One sub-module, btn_pulse: synchronizer, optional debounce and rising-edge pulse, instantiated 3 times.
- The FSM and operand registers live in the top.

Test Plan:
1. Reset then press load 4× with 78,56,34,12, then 4× with 22,22,33,33 -> a_out=32'h1234_5678, b_out=32'h3333_2222, state_out=10, byte_idx=0.
2. From WAIT_GO, op_sw=100, press go with op_ready=0 for 5 cycles then 1 -> op_valid high exactly 6 cycles, alu_op_out=100, operands stable throughout, then state_out=00.
3. Hold load_btn high 100 cycles in LOAD_A -> exactly one byte stored, byte_idx 0->1.
4. Load 2 bytes of A (FF, FF), then abort -> state_out=00, byte_idx=0, a_out[15:0]=16'hFFFF retained.
5. Assert rst_n=0 during ISSUE, asynchronously mid-cycle -> op_valid=0 and a_out=b_out=0 before the next clk edge.
6. Load and go pulses in the same cycle while in LOAD_B at byte_idx=3 -> byte stored, state -> WAIT_GO, no op_valid. With ALU_LOADER_DEBOUNCE_EN and DBNC_CYCLES=4, a 2-cycle glitch on load_btn -> no byte stored.
